// File: rtl/div_unit_if.sv
// Operand/result bundle between the issuing core (master) and div_unit (slave).
interface div_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [TAG_W-1:0] wr_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] wr_out;

  modport master (
    output start, op, src1, src2, wr_in, flush,
    input  busy, done, result, wr_out
  );

  modport slave (
    input  start, op, src1, src2, wr_in, flush,
    output busy, done, result, wr_out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU, one quotient bit per cycle.
// Optional macro DIV_SHORTCUT_EN: skip iteration when divisor is zero or |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_sgn_a;
  logic             r_sgn_b;
  logic             r_dz;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_wr_out;

  function automatic logic [WIDTH-1:0] neg_if(input logic s, input logic [WIDTH-1:0] v);
    return s ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  logic             w_signed;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_fix_val;

  assign w_signed = ~bus.op[1];
  assign w_sgn_a  = w_signed & bus.src1[WIDTH-1];
  assign w_sgn_b  = w_signed & bus.src2[WIDTH-1];
  assign w_mag_a  = neg_if(w_sgn_a, bus.src1);
  assign w_mag_b  = neg_if(w_sgn_b, bus.src2);
  assign w_accept = bus.start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // 33-bit trial subtract: the shifted partial remainder can exceed 32 bits
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift - {1'b0, r_div};

  // Truncating division: remainder follows the dividend sign; zero divisor forces all-ones
  assign w_quo_fix = r_dz ? {WIDTH{1'b1}} : neg_if(r_sgn_a ^ r_sgn_b, r_quo);
  assign w_rem_fix = neg_if(r_sgn_a, r_rem);
  assign w_fix_val = r_op[0] ? w_rem_fix : w_quo_fix;

`ifdef DIV_SHORTCUT_EN
  logic w_short;
  assign w_short = (w_mag_b == {WIDTH{1'b0}}) | (w_mag_a < w_mag_b);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_tag    <= '0;
      r_sgn_a  <= 1'b0;
      r_sgn_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_wr_out <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_tag   <= bus.wr_in;
            r_sgn_a <= w_sgn_a;
            r_sgn_b <= w_sgn_b;
            r_dz    <= (bus.src2 == {WIDTH{1'b0}});
            r_quo   <= w_mag_a;
            r_rem   <= '0;
            r_div   <= w_mag_b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
`ifdef DIV_SHORTCUT_EN
            if (w_short) begin
              r_quo   <= '0;
              r_rem   <= w_mag_a;
              r_state <= S_FIX;
            end
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_val;
          r_wr_out <= r_tag;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.wr_out = r_wr_out;
endmodule
